soc_msp430_debounce: RTL and testbench

- Switch-conditioning peripheral between the board `switch` pins and the processing unit.
- Synchronises each raw switch input to `mclk` and filters contact bounce with a per-bit programmable counter.
- Drives the debounced levels to the GPIO port input (`p1_din[3:0]`).
- Sits on the peripheral bus with its own control/status registers, and raises a maskable interrupt on each debounced edge.

---
 rtl/soc_msp430_debounce.sv | 163 ++++++++++++++++
 tb/tb_soc_msp430_debounce.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_msp430_debounce.sv
// soc_msp430_debounce: two-flop synchroniser plus per-bit programmable debounce
// filter for the board switches, with DBCTL/DBSTAT/DBIFG/DBIE peripheral
// registers and a level interrupt on every debounced edge.
// Optional macro SOC_MSP430_DEBOUNCE_SMCLK_EN: debounce counters advance only on
// smclk_en ticks; when undefined smclk_en is ignored and counters run on mclk.
module soc_msp430_debounce #(
    parameter int unsigned NUM_SW         = 4,
    parameter int unsigned CNT_W          = 16,
    parameter logic [13:0] BASE_ADDR      = 14'h0048,
    parameter logic [15:0] DEFAULT_PERIOD = 16'd5000
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic [NUM_SW-1:0] switch,
    input  logic              smclk_en,
    input  logic [13:0]       per_addr,
    input  logic [15:0]       per_din,
    input  logic              per_en,
    input  logic [1:0]        per_we,
    output logic [15:0]       per_dout,
    output logic [NUM_SW-1:0] sw_stable,
    output logic              irq_debounce
);

    localparam logic [1:0] REG_DBCTL  = 2'd0;
    localparam logic [1:0] REG_DBSTAT = 2'd1;
    localparam logic [1:0] REG_DBIFG  = 2'd2;
    localparam logic [1:0] REG_DBIE   = 2'd3;

    logic [NUM_SW-1:0] sync1;
    logic [NUM_SW-1:0] sync2;
    logic [CNT_W-1:0]  cnt      [NUM_SW];
    logic [CNT_W-1:0]  cnt_next [NUM_SW];
    logic [NUM_SW-1:0] commit;

    logic [CNT_W-1:0]  dbctl;
    logic [CNT_W-1:0]  dbctl_next;
    logic [NUM_SW-1:0] dbifg;
    logic [NUM_SW-1:0] dbifg_next;
    logic [NUM_SW-1:0] dbie;
    logic [NUM_SW-1:0] dbie_next;

    logic [13:0] reg_off;
    logic        reg_hit;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] be_mask;
    logic [15:0] wr_bits;

    logic        tick;
    logic        period_short;
    logic [CNT_W-1:0] period_last;

`ifdef SOC_MSP430_DEBOUNCE_SMCLK_EN
    assign tick = smclk_en;
`else
    logic unused_smclk_en;
    assign unused_smclk_en = smclk_en;
    assign tick            = 1'b1;
`endif

    // Address decode: four consecutive words starting at BASE_ADDR.
    assign reg_off = per_addr - BASE_ADDR;
    assign reg_hit = per_en && (reg_off < 14'd4);
    assign reg_wr  = reg_hit && (|per_we);
    assign reg_rd  = reg_hit && !(|per_we);
    assign be_mask = {{8{per_we[1]}}, {8{per_we[0]}}};
    assign wr_bits = per_din & be_mask;

    // Periods of 0 and 1 commit on the first mismatching tick.
    assign period_short = (dbctl <= CNT_W'(1));
    assign period_last  = dbctl - CNT_W'(1);

    assign irq_debounce = |(dbifg & dbie);

    // Raw pins into the mclk domain through two flops.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
        end
    end

    // Per-bit filter: count mismatching ticks, commit once the period is reached.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            commit[i]   = 1'b0;
            cnt_next[i] = cnt[i];
            if (sync2[i] == sw_stable[i]) begin
                cnt_next[i] = '0;
            end else if (tick) begin
                if (period_short || (cnt[i] >= period_last)) begin
                    commit[i]   = 1'b1;
                    cnt_next[i] = '0;
                end else if (cnt[i] != '1) begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Counter and debounced-level state.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            for (int unsigned i = 0; i < NUM_SW; i++) begin
                cnt[i] <= '0;
            end
            sw_stable <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SW; i++) begin
                cnt[i] <= cnt_next[i];
            end
            sw_stable <= sw_stable ^ commit;
        end
    end

    // Register write merge; a hardware edge flag beats a same-cycle W1C clear.
    always_comb begin
        dbctl_next = dbctl;
        dbie_next  = dbie;
        dbifg_next = dbifg;
        if (reg_wr) begin
            case (reg_off[1:0])
                REG_DBCTL: dbctl_next = (dbctl & ~CNT_W'(be_mask)) | CNT_W'(wr_bits);
                REG_DBIFG: dbifg_next = dbifg & ~NUM_SW'(wr_bits);
                REG_DBIE:  dbie_next  = (dbie & ~NUM_SW'(be_mask)) | NUM_SW'(wr_bits);
                default:   ;
            endcase
        end
        dbifg_next = dbifg_next | commit;
    end

    // Control and status register state.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            dbctl <= CNT_W'(DEFAULT_PERIOD);
            dbifg <= '0;
            dbie  <= '0;
        end else begin
            dbctl <= dbctl_next;
            dbifg <= dbifg_next;
            dbie  <= dbie_next;
        end
    end

    // Combinational read; zero when not selected so the bus can OR it in.
    always_comb begin
        per_dout = '0;
        if (reg_rd) begin
            case (reg_off[1:0])
                REG_DBCTL:  per_dout = 16'(dbctl);
                REG_DBSTAT: per_dout = 16'(sw_stable);
                REG_DBIFG:  per_dout = 16'(dbifg);
                REG_DBIE:   per_dout = 16'(dbie);
                default:    per_dout = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_msp430_debounce.sv
// Bench for soc_msp430_debounce: expected values are queued as stimulus is
// applied and popped when the corresponding DUT output is observed.
module tb_soc_msp430_debounce;

    localparam logic [13:0] A_DBCTL  = 14'h0048;
    localparam logic [13:0] A_DBSTAT = 14'h0049;
    localparam logic [13:0] A_DBIFG  = 14'h004A;
    localparam logic [13:0] A_DBIE   = 14'h004B;

    logic        mclk;
    logic        puc_rst;
    logic [3:0]  switch;
    logic        smclk_en;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [3:0]  sw_stable;
    logic        irq_debounce;

    int          vectors;
    int          miscompares;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    logic        sm_gate;
    logic [1:0]  sm_ph;

    soc_msp430_debounce dut (
        .mclk         (mclk),
        .puc_rst      (puc_rst),
        .switch       (switch),
        .smclk_en     (smclk_en),
        .per_addr     (per_addr),
        .per_din      (per_din),
        .per_en       (per_en),
        .per_we       (per_we),
        .per_dout     (per_dout),
        .sw_stable    (sw_stable),
        .irq_debounce (irq_debounce)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // smclk_en: constant 1 unless gated to one pulse every fourth cycle.
    always @(negedge mclk) begin
        sm_ph    <= sm_ph + 2'd1;
        smclk_en <= sm_gate ? (sm_ph == 2'd3) : 1'b1;
    end

    task automatic bus_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        per_en   = 1'b1;
        per_addr = a;
        per_din  = d;
        per_we   = we;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
        @(negedge mclk);
    endtask

    task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
        per_en   = 1'b1;
        per_we   = 2'b00;
        per_addr = a;
        #1;
        d      = per_dout;
        per_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        int n;
        switch  = 4'hF;
        puc_rst = 1'b1;
        repeat (3) @(negedge mclk);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'd5000);
        exp_q.push_back(32'd5002);
        exp_q.push_back(32'hF);
        puc_rst = 1'b0;
        @(posedge mclk);
        #1;
        n = 1;
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(sw_stable) !== exp_v) begin miscompares++; $display("FAIL reset_sw_stable: got %0h want %0h", sw_stable, exp_v); end
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(irq_debounce) !== exp_v) begin miscompares++; $display("FAIL reset_irq: got %0h want %0h", irq_debounce, exp_v); end
        bus_read(A_DBCTL, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL reset_dbctl: got %0d want %0d", rd, exp_v); end
        while (sw_stable !== 4'hF && n < 6000) begin
            @(posedge mclk);
            #1;
            n++;
        end
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(n) !== exp_v) begin miscompares++; $display("FAIL reset_commit_latency: got %0d want %0d", n, exp_v); end
        bus_read(A_DBIFG, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL reset_dbifg: got %0h want %0h", rd, exp_v); end
        @(negedge mclk);
    endtask

    task automatic test_bus();
        logic [15:0] rd;
        exp_q.push_back(32'h13CD);
        bus_write(A_DBCTL, 16'hABCD, 2'b01);
        bus_read(A_DBCTL, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL bus_byte_lo: got %0h want %0h", rd, exp_v); end
        exp_q.push_back(32'h00CD);
        @(negedge mclk);
        bus_write(A_DBCTL, 16'h00FF, 2'b10);
        bus_read(A_DBCTL, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL bus_byte_hi: got %0h want %0h", rd, exp_v); end
        exp_q.push_back(32'h0);
        bus_read(14'h004C, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL bus_unmapped_hi: got %0h want %0h", rd, exp_v); end
        exp_q.push_back(32'h0);
        bus_read(14'h0047, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL bus_unmapped_lo: got %0h want %0h", rd, exp_v); end
        exp_q.push_back(32'hF);
        bus_read(A_DBSTAT, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL bus_dbstat: got %0h want %0h", rd, exp_v); end
        exp_q.push_back(32'h0);
        per_addr = A_DBSTAT;
        per_we   = 2'b00;
        per_en   = 1'b0;
        #1;
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(per_dout) !== exp_v) begin miscompares++; $display("FAIL bus_idle_dout: got %0h want %0h", per_dout, exp_v); end
        exp_q.push_back(32'd10);
        @(negedge mclk);
        bus_write(A_DBCTL, 16'd10, 2'b11);
        bus_read(A_DBCTL, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL bus_full_write: got %0h want %0h", rd, exp_v); end
        @(negedge mclk);
    endtask

    task automatic test_clean_edge();
        logic [15:0] rd;
        int n;
        int irq_n;
        exp_q.push_back(32'hF);
        switch = 4'h0;
        repeat (14) @(negedge mclk);
        bus_read(A_DBIFG, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL falling_edge_flags: got %0h want %0h", rd, exp_v); end
        @(negedge mclk);
        bus_write(A_DBIFG, 16'h000F, 2'b11);
        bus_write(A_DBIE, 16'h0001, 2'b11);
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd12);
        switch[0] = 1'b1;
        n = 0;
        irq_n = 0;
        while (sw_stable[0] !== 1'b1 && n < 100) begin
            @(posedge mclk);
            #1;
            n++;
            if (irq_debounce === 1'b1 && irq_n == 0) irq_n = n;
        end
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(n) !== exp_v) begin miscompares++; $display("FAIL clean_edge_latency: got %0d want %0d", n, exp_v); end
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(irq_n) !== exp_v) begin miscompares++; $display("FAIL clean_edge_irq_latency: got %0d want %0d", irq_n, exp_v); end
        @(negedge mclk);
        exp_q.push_back(32'h1);
        bus_write(A_DBIFG, 16'h0000, 2'b11);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(irq_debounce) !== exp_v) begin miscompares++; $display("FAIL dbifg_write0_keeps: got %0h want %0h", irq_debounce, exp_v); end
        exp_q.push_back(32'h0);
        bus_write(A_DBIFG, 16'h0001, 2'b11);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(irq_debounce) !== exp_v) begin miscompares++; $display("FAIL dbifg_clear_irq: got %0h want %0h", irq_debounce, exp_v); end
    endtask

    task automatic test_bounce();
        logic [15:0] rd;
        logic early;
        int n;
        bus_write(A_DBIFG, 16'h000F, 2'b11);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'd12);
        exp_q.push_back(32'h2);
        early = 1'b0;
        switch[1] = 1'b1;
        repeat (8) begin @(negedge mclk); if (sw_stable[1] !== 1'b0) early = 1'b1; end
        switch[1] = 1'b0;
        repeat (3) begin @(negedge mclk); if (sw_stable[1] !== 1'b0) early = 1'b1; end
        switch[1] = 1'b1;
        n = 0;
        while (sw_stable[1] !== 1'b1 && n < 100) begin
            @(posedge mclk);
            #1;
            n++;
        end
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(early) !== exp_v) begin miscompares++; $display("FAIL bounce_early_commit: got %0h want %0h", early, exp_v); end
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(n) !== exp_v) begin miscompares++; $display("FAIL bounce_latency: got %0d want %0d", n, exp_v); end
        bus_read(A_DBIFG, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL bounce_dbifg: got %0h want %0h", rd, exp_v); end
        @(negedge mclk);
    endtask

    task automatic test_set_vs_clear();
        logic [15:0] rd;
        bus_write(A_DBIFG, 16'h000F, 2'b11);
        exp_q.push_back(32'h7);
        exp_q.push_back(32'h4);
        switch[2] = 1'b1;
        repeat (11) @(negedge mclk);
        bus_write(A_DBIFG, 16'h0004, 2'b11);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(sw_stable) !== exp_v) begin miscompares++; $display("FAIL setclr_sw_stable: got %0h want %0h", sw_stable, exp_v); end
        bus_read(A_DBIFG, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL setclr_set_wins: got %0h want %0h", rd, exp_v); end
        @(negedge mclk);
        exp_q.push_back(32'h0);
        bus_write(A_DBIFG, 16'h0004, 2'b11);
        bus_read(A_DBIFG, rd);
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(rd) !== exp_v) begin miscompares++; $display("FAIL setclr_later_clear: got %0h want %0h", rd, exp_v); end
        @(negedge mclk);
    endtask

    task automatic test_smclk_tick();
        int n;
        int pulses;
        int exp_n;
        bus_write(A_DBIFG, 16'h000F, 2'b11);
        bus_write(A_DBCTL, 16'd3, 2'b11);
        sm_gate = 1'b1;
        repeat (5) @(negedge mclk);
        exp_n = 0;
`ifndef SOC_MSP430_DEBOUNCE_SMCLK_EN
        exp_q.push_back(32'd5);
`endif
        switch[3] = 1'b1;
        n = 0;
        pulses = 0;
        while (sw_stable[3] !== 1'b1 && n < 100) begin
            @(posedge mclk);
            #1;
            n++;
            if (n >= 3 && smclk_en === 1'b1) begin
                pulses++;
                if (pulses == 3 && exp_n == 0) exp_n = n;
            end
        end
`ifdef SOC_MSP430_DEBOUNCE_SMCLK_EN
        exp_q.push_back(32'(exp_n));
`endif
        exp_v = exp_q.pop_front(); vectors++;
        if (32'(n) !== exp_v) begin miscompares++; $display("FAIL tick_latency: got %0d want %0d", n, exp_v); end
        sm_gate = 1'b0;
        @(negedge mclk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sm_gate     = 1'b0;
        sm_ph       = 2'd0;
        smclk_en    = 1'b1;
        puc_rst     = 1'b1;
        switch      = 4'h0;
        per_addr    = 14'h0;
        per_din     = 16'h0;
        per_en      = 1'b0;
        per_we      = 2'b00;
        test_reset();
        test_bus();
        test_clean_edge();
        test_bounce();
        test_set_vs_clear();
        test_smclk_tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
